// File: rtl/tcmp_scan_driver.sv
// Scan driver for an 8-bit identity comparator (active-low enable, active-low
// equal). Steps candidates start_val..end_val (inclusive, wrapping) onto the
// comparator B inputs, holds each for SETTLE_CYCLES+1 cycles, samples AB_n on
// the last cycle of the hold window and reports the first matching candidate.
module tcmp_scan_driver #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic       sysclk,
    input  logic       sys_rst,
    input  logic       start,
    input  logic       abort,
    input  logic [7:0] start_val,
    input  logic [7:0] end_val,
    output logic [7:0] B_7_0,
    output logic       E_n,
    input  logic       AB_n,
    output logic       busy,
    output logic       done,
    output logic       found,
    output logic [7:0] match_val
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES);

    state_t     state_q, state_d;
    logic [7:0] end_q, end_d;
    logic [3:0] settle_q, settle_d;
    logic [7:0] b_d;
    logic       e_n_d;
    logic       busy_d;
    logic       done_d;
    logic       found_d;
    logic [7:0] match_d;

    // Next-state and next-output decode for the IDLE/SCAN/DONE sequencer.
    always_comb begin
        // NOTE: every next value defaults to the current register value (done to 0)
        // before the case statement, so no path through this block can infer a latch.
        state_d  = state_q;
        end_d    = end_q;
        settle_d = settle_q;
        b_d      = B_7_0;
        e_n_d    = E_n;
        busy_d   = busy;
        done_d   = 1'b0;
        found_d  = found;
        match_d  = match_val;

        case (state_q)
            IDLE: begin
                // abort outranks start, so a simultaneous request is dropped.
                if (start && !abort) begin
                    state_d  = SCAN;
                    end_d    = end_val;
                    settle_d = 4'd0;
                    b_d      = start_val;
                    e_n_d    = 1'b0;
                    busy_d   = 1'b1;
                    found_d  = 1'b0;
                    match_d  = 8'h00;
                end
            end

            SCAN: begin
                if (abort) begin
                    // Candidate on B_7_0 is left where it was.
                    state_d  = IDLE;
                    settle_d = 4'd0;
                    e_n_d    = 1'b1;
                    busy_d   = 1'b0;
                    found_d  = 1'b0;
                    match_d  = 8'h00;
                end else if (settle_q == SETTLE_LAST) begin
                    // Only here is AB_n looked at; E_n is low for the whole SCAN state.
                    if (!AB_n) begin
                        state_d = DONE;
                        e_n_d   = 1'b1;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        found_d = 1'b1;
                        match_d = B_7_0;
                    end else if (B_7_0 != end_q) begin
                        b_d      = B_7_0 + 8'd1;
                        settle_d = 4'd0;
                    end else begin
                        state_d = DONE;
                        e_n_d   = 1'b1;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        found_d = 1'b0;
                        match_d = 8'h00;
                    end
                end else begin
                    settle_d = settle_q + 4'd1;
                end
            end

            DONE: begin
                // found/match_val hold until the next accepted start.
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
                e_n_d   = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and registered outputs; synchronous reset to the idle values.
    always_ff @(posedge sysclk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples the pre-edge values computed above.
        if (sys_rst) begin
            state_q   <= IDLE;
            end_q     <= 8'h00;
            settle_q  <= 4'd0;
            B_7_0     <= 8'h00;
            E_n       <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            found     <= 1'b0;
            match_val <= 8'h00;
        end else begin
            state_q   <= state_d;
            end_q     <= end_d;
            settle_q  <= settle_d;
            B_7_0     <= b_d;
            E_n       <= e_n_d;
            busy      <= busy_d;
            done      <= done_d;
            found     <= found_d;
            match_val <= match_d;
        end
    end

endmodule

// File: tb/tb_tcmp_scan_driver.sv
// Self-checking bench for tcmp_scan_driver. Two instances: index 0 with
// SETTLE_CYCLES=1, index 1 with SETTLE_CYCLES=0. Each has a behavioural
// comparator model; AB_n is randomised whenever E_n is high.
module tb_tcmp_scan_driver;

    logic       sysclk = 1'b0;
    logic       sys_rst;
    logic       start     [2];
    logic       abort     [2];
    logic [7:0] start_val [2];
    logic [7:0] end_val   [2];
    logic [7:0] b         [2];
    logic       e_n       [2];
    logic       ab_n      [2];
    logic       busy      [2];
    logic       done      [2];
    logic       found     [2];
    logic [7:0] match_val [2];
    logic [7:0] cmp_a     [2];
    logic       junk      [2];

    int checks = 0;
    int errors = 0;

    always #5 sysclk = ~sysclk;

    // Comparator model: equal (low) only when enabled and B matches A.
    assign ab_n[0] = e_n[0] ? junk[0] : (b[0] != cmp_a[0]);
    assign ab_n[1] = e_n[1] ? junk[1] : (b[1] != cmp_a[1]);

    // Garbage on AB_n while the comparator is disabled.
    always @(negedge sysclk) begin
        junk[0] <= 1'($urandom);
        junk[1] <= 1'($urandom);
    end

    tcmp_scan_driver #(.SETTLE_CYCLES(1)) u_s1 (
        .sysclk(sysclk), .sys_rst(sys_rst), .start(start[0]), .abort(abort[0]),
        .start_val(start_val[0]), .end_val(end_val[0]), .B_7_0(b[0]), .E_n(e_n[0]),
        .AB_n(ab_n[0]), .busy(busy[0]), .done(done[0]), .found(found[0]),
        .match_val(match_val[0])
    );

    tcmp_scan_driver #(.SETTLE_CYCLES(0)) u_s0 (
        .sysclk(sysclk), .sys_rst(sys_rst), .start(start[1]), .abort(abort[1]),
        .start_val(start_val[1]), .end_val(end_val[1]), .B_7_0(b[1]), .E_n(e_n[1]),
        .AB_n(ab_n[1]), .busy(busy[1]), .done(done[1]), .found(found[1]),
        .match_val(match_val[1])
    );

    // Run one scan on instance u and check every cycle against the model.
    // Tuple order: {busy, E_n, done, B_7_0, found, match_val}.
    // abort_at/restart_at/reset_at: edge index (after start edge 0) at which the
    // event is sampled, or -1 for none.
    task automatic run_scan(input int u, input logic [7:0] a, input logic [7:0] sv,
                            input logic [7:0] ev, input int abort_at,
                            input int restart_at, input int reset_at,
                            input string name);
        int hold, n, m, done_e, stop_e;
        logic [7:0] last_b, held_b;
        logic       exp_found;
        logic [7:0] exp_match;
        logic [19:0] exp_v, obs_v;
        hold = (u == 0) ? 2 : 1;
        n = (int'(ev) - int'(sv) + 257) % 256;
        if (n == 0) n = 256;
        m = -1;
        for (int i = 0; i < n; i++)
            if (m < 0 && 8'(int'(sv) + i) == a) m = i;
        done_e    = ((m >= 0) ? m + 1 : n) * hold;
        last_b    = 8'(int'(sv) + ((m >= 0) ? m : n - 1));
        exp_found = (m >= 0);
        exp_match = (m >= 0) ? a : 8'h00;
        held_b    = 8'(int'(sv) + ((abort_at > 0) ? (abort_at - 1) / hold : 0));
        stop_e = done_e + 1;
        if (abort_at >= 0) stop_e = abort_at + 2;
        if (reset_at >= 0) stop_e = reset_at + 1;

        cmp_a[u] = a;
        start_val[u] = sv;
        end_val[u] = ev;
        start[u] = 1'b1;
        @(posedge sysclk);
        @(negedge sysclk);
        start[u] = 1'b0;
        start_val[u] = 8'($urandom);
        end_val[u] = 8'($urandom);

        for (int e = 0; e <= stop_e; e++) begin
            if (reset_at >= 0 && e >= reset_at)
                exp_v = {1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00};
            else if (abort_at >= 0 && e >= abort_at)
                exp_v = {1'b0, 1'b1, 1'b0, held_b, 1'b0, 8'h00};
            else if (e < done_e)
                exp_v = {1'b1, 1'b0, 1'b0, 8'(int'(sv) + e / hold), 1'b0, 8'h00};
            else if (e == done_e)
                exp_v = {1'b0, 1'b1, 1'b1, last_b, exp_found, exp_match};
            else
                exp_v = {1'b0, 1'b1, 1'b0, last_b, exp_found, exp_match};
            obs_v = {busy[u], e_n[u], done[u], b[u], found[u], match_val[u]};
            checks++;
            if (obs_v !== exp_v) begin
                errors++;
                $display("FAIL %s edge %0d: {busy,E_n,done,B,found,match} got %h expected %h",
                         name, e, obs_v, exp_v);
            end
            abort[u] = (e + 1 == abort_at);
            start[u] = (e + 1 == restart_at);
            if (start[u]) start_val[u] = 8'($urandom);
            sys_rst = (e + 1 == reset_at);
            @(negedge sysclk);
        end
        abort[u] = 1'b0;
        start[u] = 1'b0;
        sys_rst = 1'b0;
    endtask

    task automatic test_reset();
        sys_rst = 1'b1;
        repeat (2) @(posedge sysclk);
        @(negedge sysclk);
        sys_rst = 1'b0;
        for (int u = 0; u < 2; u++) begin
            checks++;
            if ({busy[u], e_n[u], done[u], b[u], found[u], match_val[u]} !==
                {1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00}) begin
                errors++;
                $display("FAIL reset unit %0d: got busy=%b E_n=%b done=%b B=%h found=%b match=%h",
                         u, busy[u], e_n[u], done[u], b[u], found[u], match_val[u]);
            end
        end
    endtask

    // AB_n toggles randomly while E_n=1; nothing may change.
    task automatic test_disabled_ignored();
        cmp_a[0] = 8'h00;
        cmp_a[1] = 8'h00;
        repeat (20) begin
            @(negedge sysclk);
            for (int u = 0; u < 2; u++) begin
                checks++;
                if ({found[u], busy[u], done[u], e_n[u]} !== 4'b0001) begin
                    errors++;
                    $display("FAIL disabled_ab unit %0d: {found,busy,done,E_n} got %b expected 0001",
                             u, {found[u], busy[u], done[u], e_n[u]});
                end
            end
        end
    endtask

    task automatic test_abort_priority();
        start_val[0] = 8'h22;
        end_val[0] = 8'h33;
        start[0] = 1'b1;
        abort[0] = 1'b1;
        @(posedge sysclk);
        @(negedge sysclk);
        start[0] = 1'b0;
        abort[0] = 1'b0;
        checks++;
        if ({busy[0], e_n[0]} !== 2'b01) begin
            errors++;
            $display("FAIL abort_priority: {busy,E_n} got %b expected 01", {busy[0], e_n[0]});
        end
    endtask

    task automatic test_random();
        int u, len;
        logic [7:0] sv, a;
        for (int k = 0; k < 16; k++) begin
            u   = int'($urandom_range(0, 1));
            sv  = 8'($urandom);
            len = int'($urandom_range(0, 23));
            if ($urandom_range(0, 3) == 0) a = 8'($urandom);
            else a = 8'(int'(sv) + int'($urandom_range(0, len)));
            run_scan(u, a, sv, 8'(int'(sv) + len), -1, -1, -1, "random");
        end
    endtask

    initial begin
        sys_rst = 1'b0;
        for (int u = 0; u < 2; u++) begin
            start[u] = 1'b0;
            abort[u] = 1'b0;
            start_val[u] = 8'h00;
            end_val[u] = 8'h00;
            cmp_a[u] = 8'h00;
        end
        @(negedge sysclk);
        test_reset();
        test_disabled_ignored();
        test_abort_priority();
        run_scan(0, 8'h13, 8'h10, 8'h1F, -1, -1, -1, "match");
        run_scan(0, 8'h40, 8'h10, 8'h1F, -1, -1, -1, "no_match");
        run_scan(0, 8'h00, 8'hFE, 8'h01, -1, -1, -1, "wrap");
        run_scan(0, 8'hFF, 8'h00, 8'hFF, -1, -1, -1, "full_range");
        run_scan(0, 8'h80, 8'h00, 8'hFF, 3, -1, -1, "abort");
        run_scan(0, 8'h30, 8'h28, 8'h3F, -1, 2, -1, "start_while_busy");
        run_scan(0, 8'h30, 8'h28, 8'h3F, -1, 5, -1, "start_while_busy2");
        run_scan(0, 8'h90, 8'h80, 8'h9F, -1, -1, 5, "reset_mid_scan");
        run_scan(1, 8'h05, 8'h05, 8'h05, -1, -1, -1, "settle0_single");
        run_scan(1, 8'h07, 8'h05, 8'h05, -1, -1, -1, "settle0_single_miss");
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
